cmt_prog_seq: RTL

// - Multi-channel DCM_CLKGEN reprogramming sequencer. Takes (channel, M, D) requests and emits the serial LoadD / LoadM / GO protocol on the selected channel's progen/progdata.
// - Waits for that channel's PROGDONE, then reports completion.
// - Sits in the progclk domain beside N programmable-clock blocks; replaces ad-hoc host-driven bit-banging.

---
 rtl/cmt_prog_seq_pkg.sv | 27 ++
 rtl/cmt_prog_shifter.sv | 33 +++
 rtl/cmt_prog_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmt_prog_seq_pkg.sv
// Shared state type, command codes and frame helper for the DCM_CLKGEN reprogramming sequencer.
package cmt_prog_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadD,
    StGap1,
    StLoadM,
    StGap2,
    StGo,
    StWaitDone
  } state_e;

  // Command bits go out LSB first, so the wire order is 1,0 for LoadD and 1,1 for LoadM.
  localparam logic [1:0] CMD_LOADD = 2'b01;
  localparam logic [1:0] CMD_LOADM = 2'b11;

  localparam int unsigned LOAD_LEN = 10;
  localparam int unsigned GAP_LEN  = 2;

  // The DCM expects value-1; only the low 8 bits are sent, so 256 becomes 8'hFF.
  function automatic logic [LOAD_LEN-1:0] make_frame(input logic [1:0] cmd,
                                                     input logic [8:0] val);
    return {8'(val - 9'd1), cmd};
  endfunction

endpackage

// File: rtl/cmt_prog_shifter.sv
// Load-and-shift serializer for one LoadD/LoadM frame; bit_o is the bit on the wire this cycle.
module cmt_prog_shifter
  import cmt_prog_seq_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [LOAD_LEN-1:0] data_i,
  output logic                bit_o,
  output logic                last_o
);

  logic [LOAD_LEN-1:0] sr_q;
  logic [3:0]          cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {1'b0, sr_q[LOAD_LEN-1:1]};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign bit_o  = sr_q[0];
  assign last_o = (cnt_q == 4'(LOAD_LEN - 1));

endmodule

// File: rtl/cmt_prog_seq.sv
// Multi-channel DCM_CLKGEN reprogramming sequencer (LoadD / LoadM / GO, then wait for PROGDONE).
// Define CMT_PROG_SEQ_TIMEOUT_EN to enable the WAIT_DONE timeout, single retry and sticky ch_err.
module cmt_prog_seq
  import cmt_prog_seq_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned M_INIT  = 20,
  parameter int unsigned D_INIT  = 27,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic            progclk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CH_W-1:0] req_ch,
  input  logic [8:0]      req_m,
  input  logic [8:0]      req_d,
  output logic            done_pulse,
  output logic            inv_pulse,
  output logic [N_CH-1:0] progen,
  output logic [N_CH-1:0] progdata,
  input  logic [N_CH-1:0] progdone,
  output logic [N_CH-1:0] ch_busy,
  output logic [N_CH-1:0] ch_err
);

  localparam logic [1:0] GAP_LAST = 2'(GAP_LEN - 1);

  state_e          state_q;
  logic [CH_W-1:0] ch_q;
  logic [8:0]      m_q, d_q;
  logic [8:0]      cur_m_q [N_CH];
  logic [8:0]      cur_d_q [N_CH];
  logic [N_CH-1:0] progen_q, busy_q;
  logic            data_en_q, armed_q, ready_q, done_q, inv_q;
  logic [1:0]      gap_q;

  logic                accept, req_legal, redundant, sel_done, gap_last, complete;
  logic                idle_start, retry_go, to_fail;
  logic [8:0]          cur_m_sel, cur_d_sel;
  logic                sh_load, sh_shift, sh_bit, sh_last;
  logic [LOAD_LEN-1:0] sh_data;

`ifdef CMT_PROG_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            retry_q, to_hit;
  logic [N_CH-1:0] err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
    logic [N_CH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N_CH; i++) v[i] = (32'(c) == i);
    return v;
  endfunction

  always_comb begin
    accept    = req_valid && ready_q;
    req_legal = (req_m >= 9'd2) && (req_m <= 9'd256) && (req_d >= 9'd1) &&
                (req_d <= 9'd256) && (32'(req_ch) < N_CH);
    cur_m_sel = '0;
    cur_d_sel = '0;
    sel_done  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(req_ch) == i) begin
        cur_m_sel = cur_m_q[i];
        cur_d_sel = cur_d_q[i];
      end
      if (32'(ch_q) == i) sel_done = progdone[i];
    end
    redundant  = (req_m == cur_m_sel) && (req_d == cur_d_sel);
    gap_last   = (gap_q == GAP_LAST);
    complete   = (state_q == StWaitDone) && armed_q && sel_done;
    idle_start = (state_q == StIdle) && accept && req_legal && !redundant;
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
    to_hit   = (state_q == StWaitDone) && !complete && (to_cnt_q == TO_W'(TIMEOUT - 1));
    retry_go = to_hit && !retry_q;
    to_fail  = to_hit && retry_q;
`else
    retry_go = 1'b0;
    to_fail  = 1'b0;
`endif
    sh_load  = idle_start || retry_go || ((state_q == StGap1) && gap_last);
    sh_shift = (state_q == StLoadD) || (state_q == StLoadM);
    if (state_q == StGap1)      sh_data = make_frame(CMD_LOADM, m_q);
    else if (state_q == StIdle) sh_data = make_frame(CMD_LOADD, req_d);
    else                        sh_data = make_frame(CMD_LOADD, d_q);
  end

  cmt_prog_shifter u_shifter (
    .clk_i   (progclk),
    .rst_i   (rst),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .bit_o   (sh_bit),
    .last_o  (sh_last)
  );

  always_ff @(posedge progclk) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      m_q       <= '0;
      d_q       <= '0;
      progen_q  <= '0;
      busy_q    <= '0;
      data_en_q <= 1'b0;
      armed_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      inv_q     <= 1'b0;
      gap_q     <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cur_m_q[i] <= 9'(M_INIT);
        cur_d_q[i] <= 9'(D_INIT);
      end
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
      to_cnt_q <= '0;
      retry_q  <= 1'b0;
      err_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      inv_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            ch_q <= req_ch;
            m_q  <= req_m;
            d_q  <= req_d;
            if (!req_legal) begin
              inv_q <= 1'b1;
            end else if (redundant) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= StLoadD;
              ready_q   <= 1'b0;
              progen_q  <= ch_onehot(req_ch);
              busy_q    <= ch_onehot(req_ch);
              data_en_q <= 1'b1;
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
              retry_q <= 1'b0;
`endif
            end
          end
        end
        StLoadD, StLoadM: begin
          if (sh_last) begin
            state_q   <= (state_q == StLoadD) ? StGap1 : StGap2;
            progen_q  <= '0;
            data_en_q <= 1'b0;
            gap_q     <= '0;
          end
        end
        StGap1, StGap2: begin
          gap_q <= gap_q + 2'd1;
          if (gap_last) begin
            state_q   <= (state_q == StGap1) ? StLoadM : StGo;
            progen_q  <= ch_onehot(ch_q);
            data_en_q <= (state_q == StGap1);
          end
        end
        StGo: begin
          state_q  <= StWaitDone;
          progen_q <= '0;
          armed_q  <= 1'b0;
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        StWaitDone: begin
          // A stale high PROGDONE from the previous load must not count as completion.
          if (!sel_done) armed_q <= 1'b1;
          if (complete) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (32'(ch_q) == i) begin
                cur_m_q[i] <= m_q;
                cur_d_q[i] <= d_q;
              end
            end
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
            err_q <= err_q & ~ch_onehot(ch_q);
`endif
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= '0;
            state_q <= StIdle;
          end
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
          else if (to_fail) begin
            err_q   <= err_q | ch_onehot(ch_q);
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= '0;
            state_q <= StIdle;
          end else if (retry_go) begin
            retry_q   <= 1'b1;
            state_q   <= StLoadD;
            progen_q  <= ch_onehot(ch_q);
            data_en_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign done_pulse = done_q;
  assign inv_pulse  = inv_q;
  assign progen     = progen_q;
  assign progdata   = progen_q & {N_CH{data_en_q & sh_bit}};
  assign ch_busy    = busy_q;
`ifdef CMT_PROG_SEQ_TIMEOUT_EN
  assign ch_err = err_q;
`else
  assign ch_err = '0;
`endif

endmodule
